ir_encode_issuer: RTL and testbench

//   Encodes MIPS instruction fields (R/I/J format) into 32-bit IR words.

---
 rtl/ir_encode_issuer.sv | 140 ++++++++++++++
 tb/tb_ir_encode_issuer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_encode_issuer.sv
// MIPS R/I/J field encoder feeding a small FIFO that issues one IR word per PHASES-clock slot.
// Optional HOLD_EN macro adds a hold input that freezes the slot timing and issued word.
module ir_encode_issuer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PHASES = 5
) (
  input  logic        clk,
  input  logic        clr,
`ifdef HOLD_EN
  input  logic        hold,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  func,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] ir_out,
  output logic        ir_valid,
  output logic        slot_p0,
  output logic [2:0]  phase,
  output logic        fmt_err,
  output logic [4:0]  level
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  PH_LAST = 3'(PHASES - 1);
  localparam logic [4:0]  DEPTH_L = 5'(DEPTH);

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  logic [2:0]    phase_q, phase_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [31:0]   ir_q, ir_d;
  logic          ir_v_q, ir_v_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   word;
  logic          push, issue, pop, hold_w;

`ifdef HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  assign in_ready = (cnt_q < DEPTH_L);
  assign push     = in_valid && in_ready;
  assign issue    = (phase_q == PH_LAST) && !hold_w;
  // Pop looks at the pre-edge count, so a word written at an issue edge waits a slot.
  assign pop      = issue && (cnt_q != '0);

  always_comb begin
    word = '0;
    case (fmt_e'(fmt))
      FMT_R:   word = {op, rs, rt, rd, shamt, func};
      FMT_I:   word = {op, rs, rt, imm};
      FMT_J:   word = {op, target};
      default: word = '0;
    endcase
  end

  always_comb begin
    phase_d  = phase_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ir_d     = ir_q;
    ir_v_d   = ir_v_q;
    err_d    = err_q;
    if (!hold_w) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 3'd1;
    end
    if (issue) begin
      ir_d   = pop ? mem_q[rd_ptr_q] : '0;
      ir_v_d = pop;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (fmt_e'(fmt) == FMT_RSV) begin
        err_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ir_q     <= '0;
      ir_v_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ir_q     <= ir_d;
      ir_v_q   <= ir_v_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (clr && push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  assign ir_out   = ir_q;
  assign ir_valid = ir_v_q;
  assign slot_p0  = (phase_q == 3'd0);
  assign phase    = phase_q;
  assign fmt_err  = err_q;
  assign level    = cnt_q;

endmodule

// File: tb/tb_ir_encode_issuer.sv
// Bench for ir_encode_issuer: vector table of encodings, reference queue of issued words, slot corner cases.
module tb_ir_encode_issuer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PHASES = 5;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        hold = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = '0;
  logic [5:0]  op = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  func = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic [31:0] ir_out;
  logic        ir_valid, slot_p0, fmt_err;
  logic [2:0]  phase;
  logic [4:0]  level;

  always #5 clk = ~clk;

  ir_encode_issuer #(.DEPTH(DEPTH), .PHASES(PHASES)) dut (
    .clk(clk), .clr(clr),
`ifdef HOLD_EN
    .hold(hold),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .func(func), .imm(imm), .target(target),
    .ir_out(ir_out), .ir_valid(ir_valid), .slot_p0(slot_p0), .phase(phase),
    .fmt_err(fmt_err), .level(level)
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic        checking = 1'b0;

  // Reference model state, advanced at every rising edge
  logic [31:0] sb[$];
  logic [31:0] drv_exp = '0;
  logic [31:0] exp_ir = '0;
  logic        exp_v = 1'b0;
  logic        exp_err = 1'b0;
  int unsigned m_phase = 0;
  logic        m_iss, m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!clr) begin
      sb.delete();
      m_phase = 0;
      exp_ir  = '0;
      exp_v   = 1'b0;
      exp_err = 1'b0;
    end else begin
      m_iss = (m_phase == PHASES - 1) && !hold;
      m_acc = in_valid && (sb.size() < DEPTH);
      if (m_iss) begin
        if (sb.size() != 0) begin
          exp_ir = sb.pop_front();
          exp_v  = 1'b1;
        end else begin
          exp_ir = '0;
          exp_v  = 1'b0;
        end
      end
      if (m_acc) begin
        sb.push_back(drv_exp);
        if (fmt == 2'd3) exp_err = 1'b1;
      end
      if (!hold) m_phase = (m_phase == PHASES - 1) ? 0 : m_phase + 1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (checking) begin
        check("sb_ir_out",   ir_out,   exp_ir);
        check("sb_ir_valid", {31'b0, ir_valid}, {31'b0, exp_v});
        check("phase",       {29'b0, phase}, m_phase);
        check("slot_p0",     {31'b0, slot_p0}, {31'b0, (m_phase == 0)});
        check("level",       {27'b0, level}, sb.size());
        check("in_ready",    {31'b0, in_ready}, {31'b0, (sb.size() < DEPTH)});
        check("fmt_err",     {31'b0, fmt_err}, {31'b0, exp_err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_vec(input int i);
    int unsigned n;
    fmt = vecs[i].fmt;   op = vecs[i].op;     rs = vecs[i].rs;   rt = vecs[i].rt;
    rd = vecs[i].rd;     shamt = vecs[i].shamt; func = vecs[i].func;
    imm = vecs[i].imm;   target = vecs[i].target; drv_exp = vecs[i].exp;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_wait_bound", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int unsigned n;
    n = 0;
    while (!ir_valid && n < 4 * PHASES) begin
      tick();
      n++;
    end
    check(name, {31'b0, ir_valid}, 32'd1);
  endtask

  task automatic wait_phase(input int unsigned p);
    int unsigned n;
    n = 0;
    while (phase != 3'(p) && n < 2 * PHASES) begin
      tick();
      n++;
    end
    check("phase_align", {29'b0, phase}, p);
  endtask

  task automatic idle(input int unsigned cycles);
    for (int unsigned k = 0; k < cycles; k++) tick();
  endtask

  initial begin
    int unsigned p0_cnt;
    logic [2:0]  frz_ph;
    logic [31:0] frz_ir;

    vecs[0] = '{2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'hBEEF, 26'h2AAAAAA, 32'h00221820};
    vecs[1] = '{2'd1, 6'h08, 5'd1,  5'd2,  5'd7,  5'd9,  6'h3F, 16'h0005, 26'h1555555, 32'h20220005};
    vecs[2] = '{2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0100000, 32'h08100000};
    vecs[3] = '{2'd0, 6'h00, 5'd0,  5'd9,  5'd10, 5'd4,  6'h00, 16'h1234, 26'h3FFFFFF, 32'h00095100};
    vecs[4] = '{2'd1, 6'h23, 5'd29, 5'd31, 5'd5,  5'd6,  6'h15, 16'hFFFC, 26'h3FFFFFF, 32'h8FBFFFFC};
    vecs[5] = '{2'd2, 6'h03, 5'd1,  5'd2,  5'd3,  5'd4,  6'h05, 16'hA5A5, 26'h3FFFFFF, 32'h0FFFFFFF};
    vecs[6] = '{2'd0, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0000, 26'h0000000, 32'hFFFFFFFF};
    vecs[7] = '{2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h00000000};

    // Reset and idle slots
    tick();
    checking = 1'b1;
    tick();
    check("rst_ir_out",   ir_out, 32'h0);
    check("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("rst_level",    {27'b0, level}, 32'd0);
    check("rst_phase",    {29'b0, phase}, 32'd0);
    check("rst_fmt_err",  {31'b0, fmt_err}, 32'd0);
    clr = 1'b1;
    p0_cnt = 0;
    for (int unsigned k = 0; k < 3 * PHASES; k++) begin
      tick();
      if (slot_p0) p0_cnt++;
    end
    check("idle_p0_count", p0_cnt, 32'd3);
    check("idle_ir_out", ir_out, 32'h0);

    // Single R word, then NOP slot
    push_vec(0);
    wait_valid("r_issue_bound");
    check("r_word", ir_out, 32'h00221820);
    idle(PHASES);
    check("r_then_nop_valid", {31'b0, ir_valid}, 32'd0);
    check("r_then_nop_word", ir_out, 32'h0);

    // I then J in consecutive slots
    push_vec(1);
    push_vec(2);
    wait_valid("ij_issue_bound");
    check("i_word", ir_out, 32'h20220005);
    idle(PHASES);
    check("j_word", ir_out, 32'h08100000);
    check("j_valid", {31'b0, ir_valid}, 32'd1);
    idle(3 * PHASES);

    // Fill to DEPTH inside one slot, fifth waits for the issue edge
    wait_phase(0);
    push_vec(3);
    push_vec(4);
    push_vec(5);
    push_vec(6);
    check("full_ready", {31'b0, in_ready}, 32'd0);
    check("full_level", {27'b0, level}, 32'(DEPTH));
    push_vec(0);
    idle(6 * PHASES);

    // Push at the issue edge with empty FIFO: no bypass
    wait_phase(PHASES - 1);
    push_vec(1);
    check("nobypass_valid", {31'b0, ir_valid}, 32'd0);
    check("nobypass_level", {27'b0, level}, 32'd1);
    idle(PHASES);
    check("nobypass_word", ir_out, 32'h20220005);
    // Minimum latency: written one edge before the issue edge
    wait_phase(PHASES - 2);
    push_vec(2);
    tick();
    check("minlat_word", ir_out, 32'h08100000);
    check("minlat_valid", {31'b0, ir_valid}, 32'd1);
    idle(2 * PHASES);

    // Table-driven encodings through the scoreboard
    for (int i = 0; i < 7; i++) push_vec(i);
    idle(8 * PHASES);

    // Reserved format, sticky error, then mid-slot reset with buffered data
    push_vec(7);
    check("rsv_err", {31'b0, fmt_err}, 32'd1);
    wait_valid("rsv_issue_bound");
    check("rsv_word", ir_out, 32'h0);
    idle(2);
    check("rsv_err_sticky", {31'b0, fmt_err}, 32'd1);
    push_vec(4);
    push_vec(5);
    clr = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clr = 1'b1;
    check("mid_rst_ir_out",   ir_out, 32'h0);
    check("mid_rst_valid",    {31'b0, ir_valid}, 32'd0);
    check("mid_rst_err",      {31'b0, fmt_err}, 32'd0);
    check("mid_rst_level",    {27'b0, level}, 32'd0);
    check("mid_rst_phase",    {29'b0, phase}, 32'd0);
    idle(2 * PHASES);

`ifdef HOLD_EN
    push_vec(3);
    wait_valid("hold_issue_bound");
    idle(2);
    frz_ph = phase;
    frz_ir = ir_out;
    hold = 1'b1;
    for (int unsigned k = 0; k < 7; k++) begin
      tick();
      check("hold_phase", {29'b0, phase}, {29'b0, frz_ph});
      check("hold_ir_out", ir_out, frz_ir);
    end
    push_vec(6);
    hold = 1'b0;
    idle(3 * PHASES);
`else
    frz_ph = '0;
    frz_ir = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
